// File: rtl/nav_pkg.sv
// Shared types and default timing constants for the auto_navigator decision stage.
package nav_pkg;

    localparam int unsigned DEF_SETTLE_CYCLES  = 10;
    localparam int unsigned DEF_ACK_TIMEOUT    = 4;
    localparam int unsigned DEF_ADVANCE_CYCLES = 250;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CRUISE   = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_WAIT_ACK = 3'd4,
        ST_TURNING  = 3'd5,
        ST_ADVANCE  = 3'd6,
        ST_STUCK    = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        DEC_NONE,
        DEC_LEFT,
        DEC_RIGHT,
        DEC_BACK,
        DEC_STUCK
    } decision_t;

    // Right-hand wall following on a {front, left, right, back} snapshot, first match wins.
    function automatic decision_t decide(input logic [3:0] v);
        if (!v[1]) return DEC_RIGHT;
        if (!v[3]) return DEC_NONE;
        if (!v[2]) return DEC_LEFT;
        if (!v[0]) return DEC_BACK;
        return DEC_STUCK;
    endfunction

endpackage

// File: rtl/detector_settle.sv
// Detector snapshot register with a stability counter; settled flags a vector
// that has matched the snapshot for SETTLE_CYCLES consecutive samples.
module detector_settle
    import nav_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] vec,
    output logic       settled,
    output logic [3:0] snap
);

    localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Latch on start or on any change; otherwise count matching samples, saturating at the terminal value.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap <= '0;
            cnt  <= '0;
        end else if (start || (vec != snap)) begin
            snap <= vec;
            cnt  <= '0;
        end else if (cnt != CNT_LAST) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign settled = (cnt == CNT_LAST) && (vec == snap);

endmodule

// File: rtl/auto_navigator.sv
// Junction decision FSM: debounces detectors, picks a right-hand-rule manoeuvre,
// pulses one trigger, waits for the executor handshake, then advances.
module auto_navigator
    import nav_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int unsigned ACK_TIMEOUT    = DEF_ACK_TIMEOUT,
    parameter int unsigned ADVANCE_CYCLES = DEF_ADVANCE_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       detect_front,
    input  logic       detect_left,
    input  logic       detect_right,
    input  logic       detect_back,
    input  logic       is_turning,
    output logic       trigger_turn_left,
    output logic       trigger_turn_right,
    output logic       trigger_turn_back,
    output logic       move_forward,
    output logic       stuck,
    output logic [7:0] turn_count,
    output logic [2:0] state
);

    localparam int unsigned AW = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned VW = $clog2(ADVANCE_CYCLES + 1);
    localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TIMEOUT - 1);
    localparam logic [VW-1:0] ADV_LAST = VW'(ADVANCE_CYCLES - 1);

    state_t        state_q, state_d;
    decision_t     dec;
    logic [3:0]    vec, snap;
    logic          settled, settle_start, ack_hit, junction;
    logic [AW-1:0] ack_cnt;
    logic [VW-1:0] adv_cnt;
    logic          trig_l_d, trig_r_d, trig_b_d, move_d, stuck_d;

    assign vec      = {detect_front, detect_left, detect_right, detect_back};
    assign junction = !detect_right || detect_front;
    assign dec      = decide(snap);

    detector_settle #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle (
        .clk    (clk),
        .rst    (rst),
        .start  (settle_start),
        .vec    (vec),
        .settled(settled),
        .snap   (snap)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; enable low overrides every transition.
    always_comb begin
        state_d      = state_q;
        settle_start = 1'b0;
        ack_hit      = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_CRUISE;
                ST_CRUISE: if (junction && !is_turning) begin
                    state_d      = ST_SETTLE;
                    settle_start = 1'b1;
                end
                ST_SETTLE: if (settled) begin
                    case (dec)
                        DEC_NONE:  state_d = ST_CRUISE;
                        DEC_STUCK: state_d = ST_STUCK;
                        default:   state_d = ST_ISSUE;
                    endcase
                end
                ST_ISSUE:  state_d = ST_WAIT_ACK;
                ST_WAIT_ACK: begin
                    if (is_turning) begin
                        state_d = ST_TURNING;
                        ack_hit = 1'b1;
                    end else if (ack_cnt == ACK_LAST) begin
                        state_d      = ST_SETTLE;
                        settle_start = 1'b1;
                    end
                end
                ST_TURNING: if (!is_turning) state_d = ST_ADVANCE;
                ST_ADVANCE: if (adv_cnt == ADV_LAST) state_d = ST_CRUISE;
                ST_STUCK: if (vec != 4'hF) begin
                    state_d      = ST_SETTLE;
                    settle_start = 1'b1;
                end
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Output decode from the next state so every output can be registered alongside it.
    always_comb begin
        trig_l_d = 1'b0;
        trig_r_d = 1'b0;
        trig_b_d = 1'b0;
        if (state_d == ST_ISSUE) begin
            case (dec)
                DEC_LEFT:  trig_l_d = 1'b1;
                DEC_RIGHT: trig_r_d = 1'b1;
                DEC_BACK:  trig_b_d = 1'b1;
                default:   ;
            endcase
        end
        move_d  = (state_d == ST_CRUISE) || (state_d == ST_ADVANCE);
        stuck_d = (state_d == ST_STUCK);
    end

    // Registered outputs and accepted-turn counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            trigger_turn_left  <= 1'b0;
            trigger_turn_right <= 1'b0;
            trigger_turn_back  <= 1'b0;
            move_forward       <= 1'b0;
            stuck              <= 1'b0;
            turn_count         <= '0;
        end else begin
            trigger_turn_left  <= trig_l_d;
            trigger_turn_right <= trig_r_d;
            trigger_turn_back  <= trig_b_d;
            move_forward       <= move_d;
            stuck              <= stuck_d;
            if (ack_hit) turn_count <= turn_count + 8'd1;
        end
    end

    // Handshake timeout and advance counters, held at zero outside their states.
    always_ff @(posedge clk) begin
        if (rst || state_q != ST_WAIT_ACK) ack_cnt <= '0;
        else if (ack_cnt != ACK_LAST)      ack_cnt <= ack_cnt + AW'(1);

        if (rst || state_q != ST_ADVANCE)  adv_cnt <= '0;
        else if (adv_cnt != ADV_LAST)      adv_cnt <= adv_cnt + VW'(1);
    end

    assign state = state_q;

endmodule

// File: tb/tb_auto_navigator.sv
// Directed bench for auto_navigator with a cycle-level reference model and literal checkpoints.
module tb_auto_navigator;
    import nav_pkg::*;

    localparam int unsigned S = 3;
    localparam int unsigned T = 4;
    localparam int unsigned N = 5;

    logic clk = 1'b0;
    logic rst, enable, df, dl, dr, db, busy;
    logic tl, tr, tb, mf, stk;
    logic [7:0] tc;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    auto_navigator #(
        .SETTLE_CYCLES (S),
        .ACK_TIMEOUT   (T),
        .ADVANCE_CYCLES(N)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .detect_front      (df),
        .detect_left       (dl),
        .detect_right      (dr),
        .detect_back       (db),
        .is_turning        (busy),
        .trigger_turn_left (tl),
        .trigger_turn_right(tr),
        .trigger_turn_back (tb),
        .move_forward      (mf),
        .stuck             (stk),
        .turn_count        (tc),
        .state             (state)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    // Manoeuvre codes: 0 none, 1 left, 2 right, 3 back, 4 stuck.
    function automatic int pick(input logic [3:0] v);
        logic f, l, r, b;
        {f, l, r, b} = v;
        if (r == 1'b0) return 2;
        if (f == 1'b0) return 0;
        if (l == 1'b0) return 1;
        if (b == 1'b0) return 3;
        return 4;
    endfunction

    state_t     m_st = ST_IDLE;
    logic [3:0] m_snap = '0;
    logic [3:0] m_v;
    int         m_matches = 0;
    int         m_remaining = 0;
    int         m_tc = 0;
    int         m_choice;
    logic       m_tl = 0, m_tr = 0, m_tb = 0, m_mf = 0, m_stk = 0;

    always @(posedge clk) begin
        m_v  = {df, dl, dr, db};
        m_tl = 0; m_tr = 0; m_tb = 0;
        if (rst) begin
            m_st = ST_IDLE; m_tc = 0; m_snap = '0; m_matches = 0; m_remaining = 0;
        end else if (!enable) begin
            m_st = ST_IDLE;
        end else begin
            case (m_st)
                ST_IDLE:   m_st = ST_CRUISE;
                ST_CRUISE: if ((!dr || df) && !busy) begin
                    m_st = ST_SETTLE; m_snap = m_v; m_matches = 0;
                end
                ST_SETTLE: begin
                    if (m_v != m_snap) begin
                        m_snap = m_v; m_matches = 0;
                    end else begin
                        m_matches++;
                        if (m_matches == int'(S)) begin
                            m_choice = pick(m_snap);
                            if (m_choice == 0)      m_st = ST_CRUISE;
                            else if (m_choice == 4) m_st = ST_STUCK;
                            else begin
                                m_st = ST_ISSUE;
                                m_tl = (m_choice == 1);
                                m_tr = (m_choice == 2);
                                m_tb = (m_choice == 3);
                            end
                        end
                    end
                end
                ST_ISSUE: begin m_st = ST_WAIT_ACK; m_remaining = T; end
                ST_WAIT_ACK: begin
                    if (busy) begin
                        m_st = ST_TURNING; m_tc = (m_tc + 1) % 256;
                    end else begin
                        m_remaining--;
                        if (m_remaining == 0) begin
                            m_st = ST_SETTLE; m_snap = m_v; m_matches = 0;
                        end
                    end
                end
                ST_TURNING: if (!busy) begin m_st = ST_ADVANCE; m_remaining = N; end
                ST_ADVANCE: begin
                    m_remaining--;
                    if (m_remaining == 0) m_st = ST_CRUISE;
                end
                ST_STUCK: if (m_v != 4'hF) begin
                    m_st = ST_SETTLE; m_snap = m_v; m_matches = 0;
                end
                default: m_st = ST_IDLE;
            endcase
        end
        m_mf  = (m_st == ST_CRUISE) || (m_st == ST_ADVANCE);
        m_stk = (m_st == ST_STUCK);
    end

    // Every-cycle comparison against the model, clear of the active edge.
    always @(posedge clk) begin
        #2;
        chk("outputs{tl,tr,tb,mf,stuck,count,state}",
            {16'd0, tl, tr, tb, mf, stk, tc, state},
            {16'd0, m_tl, m_tr, m_tb, m_mf, m_stk, 8'(m_tc), m_st});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_det(input logic f, input logic l, input logic r, input logic b);
        df = f; dl = l; dr = r; db = b;
    endtask

    task automatic wait_trig(input logic [2:0] want, input int max, output int n);
        n = 0;
        while ({tl, tr, tb} !== want && n < max) begin
            @(negedge clk);
            n++;
        end
        if ({tl, tr, tb} !== want) begin
            n_checks++; n_fail++;
            $display("FAIL wait_trig: got %b, expected %b within %0d cycles", {tl, tr, tb}, want, max);
        end
    endtask

    task automatic wait_state(input logic [2:0] want, input int max);
        int n;
        n = 0;
        while (state !== want && n < max) begin
            @(negedge clk);
            n++;
        end
        if (state !== want) begin
            n_checks++; n_fail++;
            $display("FAIL wait_state: got %0d, expected %0d within %0d cycles", state, want, max);
        end
    endtask

    // One right turn accepted by the executor, ending back in CRUISE.
    task automatic do_turn();
        int n;
        set_det(0, 1, 0, 1);
        wait_trig(3'b010, 20, n);
        busy = 1;
        set_det(0, 1, 1, 1);
        tick(2);
        busy = 0;
        wait_state(ST_CRUISE, 20);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1; enable = 0; busy = 0;
        set_det(0, 1, 1, 1);

        // Reset, then enable: CRUISE one edge after release.
        tick(2);
        chk("reset_state", state, 3'd0);
        chk("reset_outs", {tl, tr, tb, mf, stk, tc}, 13'd0);
        rst = 0; enable = 1;
        tick(1);
        chk("cruise_after_reset", state, 3'd1);
        chk("move_after_reset", mf, 1'b1);

        // Right opening: trigger 3 edges after SETTLE entry, ack for 10 cycles, advance 5.
        set_det(0, 1, 0, 1);
        wait_trig(3'b010, 20, n);
        chk("right_latency", n, 4);
        busy = 1;
        set_det(0, 1, 1, 1);
        tick(1);
        chk("right_pulse_len", tr, 1'b0);
        tick(9);
        chk("turning_state", state, 3'd5);
        chk("count_after_right", tc, 8'd1);
        busy = 0;
        tick(5);
        chk("advance_state", state, 3'd6);
        chk("advance_move", mf, 1'b1);
        tick(1);
        chk("cruise_after_advance", state, 3'd1);

        // Dead end: back turn.
        set_det(1, 1, 1, 0);
        wait_trig(3'b001, 20, n);
        chk("back_latency", n, 4);
        busy = 1;
        set_det(0, 1, 1, 1);
        tick(2);
        busy = 0;
        wait_state(ST_CRUISE, 20);
        chk("count_after_back", tc, 8'd2);

        // Boxed in, then left opens.
        set_det(1, 1, 1, 1);
        wait_state(ST_STUCK, 20);
        chk("stuck_flag", stk, 1'b1);
        chk("stuck_no_move", mf, 1'b0);
        set_det(1, 0, 1, 1);
        wait_trig(3'b100, 20, n);
        chk("left_latency", n, 4);
        busy = 1;
        set_det(0, 1, 1, 1);
        tick(2);
        busy = 0;
        wait_state(ST_CRUISE, 20);
        chk("count_after_left", tc, 8'd3);

        // Glitch on the 2nd settle cycle restarts settling.
        set_det(0, 1, 0, 1);
        tick(2);
        set_det(0, 1, 1, 1);
        tick(1);
        set_det(0, 1, 0, 1);
        wait_trig(3'b010, 20, n);
        chk("glitch_latency", n, 4);

        // No acknowledge: timeout, re-settle, second pulse.
        tick(1);
        wait_trig(3'b010, 20, n);
        chk("retry_spacing", n, 7);
        chk("count_no_ack", tc, 8'd3);
        // Acknowledge arrives on the expiring cycle and wins.
        tick(4);
        busy = 1;
        tick(1);
        chk("ack_beats_timeout", state, 3'd5);
        chk("count_ack_on_expiry", tc, 8'd4);
        busy = 0;
        set_det(0, 1, 1, 1);
        wait_state(ST_CRUISE, 20);

        // Executor busy at a junction: stay in CRUISE.
        busy = 1;
        set_det(0, 1, 0, 1);
        tick(3);
        chk("busy_holds_cruise", state, 3'd1);
        busy = 0;
        wait_trig(3'b010, 20, n);
        chk("latency_after_busy", n, 4);
        busy = 1;
        set_det(0, 1, 1, 1);
        tick(2);
        chk("turning_before_abort", state, 3'd5);

        // Abort mid-turn with enable low.
        enable = 0;
        tick(1);
        chk("abort_state", state, 3'd0);
        chk("abort_outs", {tl, tr, tb, mf, stk}, 5'd0);
        chk("abort_keeps_count", tc, 8'd5);
        busy = 0;
        tick(2);
        enable = 1;
        wait_state(ST_CRUISE, 20);

        // Wrap of the accepted-turn counter.
        repeat (250) do_turn();
        chk("count_255", tc, 8'd255);
        do_turn();
        chk("count_wrap", tc, 8'd0);

        // Reset mid-operation clears the counter.
        do_turn();
        rst = 1;
        tick(1);
        chk("rst_clears_count", tc, 8'd0);
        chk("rst_state", state, 3'd0);
        rst = 0;
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/auto_navigator.md
# auto_navigator

Decision stage directly upstream of the auto-turn executor in the car's autonomous-drive path. Watches the four obstacle detectors and debounces the detector vector at junctions. Picks a manoeuvre by the right-hand wall-following rule, sends it as a single-cycle trigger, and waits for the executor's `is_turning` handshake. It then drives forward long enough to clear the junction before looking for the next one.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 10: consecutive cycles the detector vector must be stable before a decision (20 ms at 500 Hz). Must be ≥1.
- `ACK_TIMEOUT`, default 4: cycles allowed for `is_turning` to rise after a trigger. Must be ≥1.
- `ADVANCE_CYCLES`, default 250: forward-drive cycles after a turn completes, with detectors ignored (0.5 s). Must be ≥1.

Ports:
- `clk`  in  1: 500 Hz system clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `enable`  in  1: autonomous mode active. Low forces IDLE.
- `detect_front`, `detect_left`, `detect_right`, `detect_back`  in  1 each: 1 means an obstacle or wall in that direction.
- `is_turning`  in  1: busy flag from the turn executor.
- `trigger_turn_left`, `trigger_turn_right`, `trigger_turn_back`  out  1 each: one-cycle request pulses, mutually exclusive.
- `move_forward`  out  1: drive-forward command.
- `stuck`  out  1: high when boxed in on all four sides.
- `turn_count`  out  8: number of triggers accepted by the executor, wraps modulo 256.
- `state`  out  3: current FSM state, for debug LEDs.

## Operation
- All outputs are registered. Reset values: every output 0, `state` = IDLE, internal counters 0.
- The junction condition is `!detect_right || detect_front`.
- Decision on the settled snapshot, first match wins:
  - right open → RIGHT
  - front open → NONE
  - left open → LEFT
  - back open → BACK
  - otherwise → STUCK
- FSM:
  - **IDLE**: when `enable` is 1, go to CRUISE.
  - **CRUISE**: `move_forward` = 1. If the junction condition holds and `is_turning` is 0, go to SETTLE, latch the detector snapshot and clear the settle counter.
  - **SETTLE**: `move_forward` = 0.
    - If the vector differs from the snapshot, re-latch the snapshot and clear the counter.
    - Otherwise increment the counter. When it reaches `SETTLE_CYCLES-1` with a match, decide:
      - NONE → CRUISE
      - STUCK → STUCK
      - RIGHT, LEFT or BACK → ISSUE
  - **ISSUE**: exactly one trigger is high for exactly this one cycle. Then go to WAIT_ACK and clear the timeout counter.
  - **WAIT_ACK**:
    - If `is_turning` is 1, go to TURNING and increment `turn_count`.
    - Else if the timeout counter reaches `ACK_TIMEOUT-1`, go to SETTLE (full re-decision, new snapshot).
  - **TURNING**: hold until `is_turning` is 0, then go to ADVANCE and clear the advance counter.
  - **ADVANCE**: `move_forward` = 1 and detectors are ignored. After `ADVANCE_CYCLES` cycles, go to CRUISE.
  - **STUCK**: `stuck` = 1, `move_forward` = 0. If any detector reads 0, go to SETTLE.
- Counter widths are `$clog2(P+1)` for each parameter P. No counter may wrap before its terminal compare.

## Timing
- Priority: `rst` > `enable` low > FSM transitions.
- `enable` low in any state: at the next edge go to IDLE, clear all outputs, and drop any pending trigger. This holds even mid-SETTLE or mid-TURNING. No trigger is ever issued after `enable` falls.
- `rst` mid-operation has the same effect as `enable` low, and also clears `turn_count`.
- Latency to trigger: snapshot latched at edge E0 with a stable vector → trigger high from edge E0+`SETTLE_CYCLES` for one cycle.
- `turn_count` updates at the edge leaving WAIT_ACK. 255 + 1 = 0.
- Executor already busy when a junction appears: CRUISE stays in CRUISE until `is_turning` is 0.
- `is_turning` rising in the same cycle the timeout expires: acknowledge wins, go to TURNING.
- Detector glitch on the final settle cycle: re-latch the snapshot. No decision is taken that cycle.

## Structure
- Shared package `nav_pkg` holds:
  - the state enum (IDLE, CRUISE, SETTLE, ISSUE, WAIT_ACK, TURNING, ADVANCE, STUCK), 3-bit encoding;
  - the decision enum (NONE, LEFT, RIGHT, BACK, STUCK);
  - the default timing constants.
- One sub-module, `detector_settle`: snapshot register plus stability counter. Ports: `clk`, `rst`, `start`, `vec[3:0]`, `settled`, `snap[3:0]`. The FSM, decision logic and counters stay in `auto_navigator`.

## Test plan
Use `SETTLE_CYCLES`=3, `ACK_TIMEOUT`=4, `ADVANCE_CYCLES`=5 unless noted.
- Reset: `rst`=1 for 2 cycles, then `enable`=1 → all outputs 0 during reset, CRUISE with `move_forward`=1 one cycle after release.
- Right opening: in CRUISE, detectors F=0 L=1 R=0 B=1 held stable → `trigger_turn_right` high for exactly 1 cycle, 3 edges after SETTLE entry. Then `is_turning` high for 10 cycles → `turn_count`=1, then `move_forward`=1 for 5 cycles, then CRUISE.
- Dead end: F=1 L=1 R=1 B=0 → `trigger_turn_back` pulse. With all four detectors =1 instead → `stuck`=1 and `move_forward`=0. Lowering L → SETTLE, then `trigger_turn_left`.
- Glitch: toggle R on the 2nd settle cycle → settle restarts, and the trigger appears 3 edges after the last change.
- No acknowledge: `is_turning` held 0 → trigger, 4 cycles in WAIT_ACK, return to SETTLE, second trigger pulse. `turn_count` unchanged.
- Abort and wrap: drop `enable` during TURNING → IDLE and all outputs 0 next edge. Separately, preload 255 accepted turns and do one more → `turn_count`=0.
